// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Data-memory access unit for the MEM stage of the MIPS pipeline. A load or
//   store instruction becomes one request/acknowledge transaction on a
//   word-wide data bus. Stores are handled with byte and halfword lane
//   replication, and loads are sign or zero extended. The pipeline is stalled
//   while the transaction is in flight.
//
//   Optional feature macro: LSU_ALIGN_CHECK_EN
//     When defined, misaligned halfword and word accesses skip the bus and
//     pulse misalign_lsu_o. When undefined, misalign_lsu_o is tied low and the
//     low address bits are ignored for those sizes.
//
// Ports
//   clk, rst           pipeline clock, asynchronous active-high reset
//   mem_read_lsu_i     memory-read control from decode
//   mem_wr_lsu_i       memory-write control from decode
//   instr_op_lsu_i     opcode of the MEM-stage instruction
//   addr_lsu_i         effective address
//   wr_data_lsu_i      store data (rt)
//   stall_lsu_o        pipeline hold while an access is in progress
//   rd_data_lsu_o      extended load result (held until the next load)
//   rd_valid_lsu_o     one-cycle load-result strobe
//   misalign_lsu_o     one-cycle misaligned-access flag
//   dmem_req_o/we_o    bus request / write enable
//   dmem_addr_o        word-aligned bus address
//   dmem_be_o          byte enables (bit n covers data[8n+7:8n])
//   dmem_wdata_o       lane-replicated store data
//   dmem_ack_i         bus acknowledge (read data valid in the same cycle)
//   dmem_rdata_i       bus read word
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_lsu_i,
  input  logic        mem_wr_lsu_i,
  input  logic [5:0]  instr_op_lsu_i,
  input  logic [31:0] addr_lsu_i,
  input  logic [31:0] wr_data_lsu_i,
  output logic        stall_lsu_o,
  output logic [31:0] rd_data_lsu_o,
  output logic        rd_valid_lsu_o,
  output logic        misalign_lsu_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Access size is encoded in opcode bits [1:0] for every load/store:
  // 00 byte, 01 halfword, 11 word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: is_load = 1'b1;
      default:                                               is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      6'b101000, 6'b101001, 6'b101011: is_store = 1'b1;
      default:                         is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: store_data = {4{wd[7:0]}};
      SZ_HALF: store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic        sext,
                                               input logic [1:0]  lo,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{sext & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sext & h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction
`endif

  state_e      state_q, state_d;
  logic        ld_s, st_s, start_s, misalign_s;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        store_q;
  logic        misalign_q;
  logic [1:0]  addr_lo_q;
  logic [29:0] word_addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_data_q;

  assign ld_s    = mem_read_lsu_i & is_load(instr_op_lsu_i);
  assign st_s    = mem_wr_lsu_i & is_store(instr_op_lsu_i);
  assign start_s = ld_s | st_s;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign_s = misaligned(instr_op_lsu_i[1:0], addr_lsu_i[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // State register; reset returns to IDLE at once, even mid-request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = misalign_s ? ST_DONE : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_ack_i) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Access latch at the IDLE edge and load-result capture on acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      store_q     <= 1'b0;
      misalign_q  <= 1'b0;
      addr_lo_q   <= 2'b00;
      word_addr_q <= 30'd0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'd0;
      rd_data_q   <= 32'd0;
    end else begin
      if ((state_q == ST_IDLE) && start_s) begin
        size_q      <= instr_op_lsu_i[1:0];
        sext_q      <= ~instr_op_lsu_i[2];   // LBU/LHU have bit 2 set
        store_q     <= st_s;
        misalign_q  <= misalign_s;
        addr_lo_q   <= addr_lsu_i[1:0];
        word_addr_q <= addr_lsu_i[31:2];
        be_q        <= byte_en(instr_op_lsu_i[1:0], addr_lsu_i[1:0]);
        wdata_q     <= store_data(instr_op_lsu_i[1:0], wr_data_lsu_i);
      end
      if ((state_q == ST_REQ) && dmem_ack_i && !store_q) begin
        rd_data_q <= load_extract(size_q, sext_q, addr_lo_q, dmem_rdata_i);
      end
    end
  end

  // Output decode from state and latched access fields. Stall in IDLE is
  // combinational so the instruction is held on the very cycle it is seen.
  always_comb begin
    stall_lsu_o    = 1'b0;
    dmem_req_o     = 1'b0;
    dmem_we_o      = 1'b0;
    rd_valid_lsu_o = 1'b0;
    misalign_lsu_o = 1'b0;
    case (state_q)
      ST_IDLE: stall_lsu_o = start_s;
      ST_REQ: begin
        stall_lsu_o = 1'b1;
        dmem_req_o  = 1'b1;
        dmem_we_o   = store_q;
      end
      ST_DONE: begin
        rd_valid_lsu_o = ~store_q & ~misalign_q;
        misalign_lsu_o = misalign_q;
      end
      default: stall_lsu_o = 1'b0;
    endcase
  end

  assign dmem_addr_o   = {word_addr_q, 2'b00};
  assign dmem_be_o     = be_q;
  assign dmem_wdata_o  = wdata_q;
  assign rd_data_lsu_o = rd_data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access unit for the MIPS pipeline. It receives the memory-read and memory-write controls and the opcode that instruction decode produces, and turns them into a request/acknowledge transaction on the data-memory bus. It handles byte and halfword lanes for stores and sign or zero extension for loads. While a transaction is outstanding it stalls the pipeline, and it releases the stall with the load result in the MEM stage.

## Interface
- No parameters. Data and address are fixed at 32 bits; the bus is word-wide.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- mem_read_lsu_i  in  1  memory-read control from decode
- mem_wr_lsu_i  in  1  memory-write control from decode
- instr_op_lsu_i  in  6  opcode of the MEM-stage instruction
- addr_lsu_i  in  32  effective address (ALU result)
- wr_data_lsu_i  in  32  store data (rt)
- stall_lsu_o  out  1  holds the pipeline while an access is in progress
- rd_data_lsu_o  out  32  extended load result
- rd_valid_lsu_o  out  1  load result valid (one cycle)
- misalign_lsu_o  out  1  misaligned-access flag (one cycle)
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  bus write enable
- dmem_addr_o  out  32  word address, `{addr[31:2],2'b00}`
- dmem_be_o  out  4  byte enables; bit n covers data bits [8n+7:8n]
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ack_i  in  1  bus acknowledge; read data is valid in the same cycle
- dmem_rdata_i  in  32  bus read word

## Operation
- Lane ordering is little-endian: byte lane = addr[1:0].
- **Valid loads:** LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101.
- **Valid stores:** SB 101000, SH 101001, SW 101011.
- **Access start:** an access starts only when (mem_read & the opcode is a load) or (mem_wr & the opcode is a store). Every other combination is ignored: no stall and no bus cycle. This includes LUI, which decode flags as mem_read.
- **Byte enables:**
  - Byte access: `4'b0001 << addr[1:0]`.
  - Halfword access: addr[1] ? 1100 : 0011.
  - Word access: 1111.
  - Loads drive the same byte enables as stores.
- **Store data:**
  - SB: wr_data[7:0] replicated ×4.
  - SH: wr_data[15:0] replicated ×2.
  - SW: wr_data unchanged.
- **Load data:** the selected lane is extracted. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- **State machine (IDLE, REQ, DONE):**
  - IDLE: a valid access raises stall_lsu_o combinationally. At the clock edge the unit latches op, address, byte enables and write data, then moves to REQ.
  - REQ: dmem_req_o=1 and dmem_we_o=store, driven from registers. stall_lsu_o=1. On dmem_ack_i=1 the unit captures the extended read data and moves to DONE. Otherwise it stays in REQ with all bus outputs held stable.
  - DONE: stall_lsu_o=0. For loads, rd_valid_lsu_o=1. The pipeline advances at this edge. The unit returns to IDLE and does not re-sample its inputs during DONE.
- rd_data_lsu_o holds its last captured value until the next load completes.
- dmem_ack_i is ignored in IDLE and DONE.
- **Reset:** rst forces IDLE immediately, including in the middle of REQ; dmem_req_o drops asynchronously.
- **Reset values:** every output is 0, i.e. stall, rd_data, rd_valid, misalign, req, we, addr, be and wdata.

## Timing
- Cycle 0 (IDLE): request seen, stall=1.
- Cycle 1 (REQ): req=1. With ack in the same cycle, the unit reaches DONE in cycle 2.
- Minimum stall is 2 cycles. Each wait-state cycle adds 1.
- rd_valid and the new rd_data appear in DONE, which is 1 cycle after the ack cycle.
- Back-to-back accesses: the next instruction is sampled in the IDLE cycle after DONE. The minimum period between accesses is therefore 3 cycles.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, goes from IDLE directly to DONE with no bus cycle.
  - misalign_lsu_o=1 for that DONE cycle only; rd_valid=0; rd_data is unchanged.
  - stall is held for 1 cycle, the IDLE cycle.
- `LSU_ALIGN_CHECK_EN` undefined:
  - misalign_lsu_o is tied to 0.
  - Halfword accesses ignore addr[0], and word accesses ignore addr[1:0].
  - A bus cycle is always issued.

## Test plan
- LW to 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF:
  - req held for 3 cycles; addr=0x100, be=1111, we=0.
  - stall high for 4 cycles.
  - rd_data=0xDEADBEEF with rd_valid pulsed once.
- LB at 0x203 with rdata 0x80FF_0000 → be=1000, rd_data=0xFFFFFF80. The same access as LBU → rd_data=0x00000080.
- SH at 0x402 with wr_data 0x1234ABCD, ack immediate:
  - be=1100, wdata=0xABCDABCD, we=1.
  - stall high for exactly 2 cycles; rd_valid stays 0.
- mem_read=1 with opcode 001111 (LUI) → no req and no stall for any number of cycles.
- rst asserted in REQ with no ack → req, stall and be drop within the reset cycle. The state is IDLE, and a later LW completes normally.
- With `LSU_ALIGN_CHECK_EN`, LW at 0x102 → no req, misalign pulses for 1 cycle, stall held for 1 cycle. Without the macro, the same access → addr=0x100, be=1111, misalign stays 0.
